// File: rtl/inj_trig_sequencer.sv
// Scan sequencer: repeated injection pulse, delayed trigger window, fixed period,
// with FIFO back-pressure hold and abort. One START runs a whole scan.
module inj_trig_sequencer #(
   parameter int unsigned CNT_WIDTH = 16,
   parameter int unsigned DLY_WIDTH = 8
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST_N,
   input  logic                 START,
   input  logic                 ABORT,
   input  logic [CNT_WIDTH-1:0] REPEAT,
   input  logic [DLY_WIDTH-1:0] INJ_WIDTH,
   input  logic [DLY_WIDTH-1:0] TRIG_DELAY,
   input  logic [DLY_WIDTH-1:0] TRIG_WIDTH,
   input  logic [CNT_WIDTH-1:0] PERIOD,
   input  logic                 FIFO_NEAR_FULL,
   output logic                 INJ_PULSE,
   output logic                 TRIG,
   output logic                 BUSY,
   output logic                 PAUSED,
   output logic                 DONE,
   output logic [CNT_WIDTH-1:0] INJ_COUNT
);

   typedef enum logic [2:0] {
      StIdle, StInj, StDelay, StTrig, StWait, StHold, StDone
   } state_e;

   localparam logic [DLY_WIDTH-1:0] DlyOne  = DLY_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH:0]   CntOneW = (CNT_WIDTH + 1)'(1);

   state_e               r_state, w_state_d;
   logic [CNT_WIDTH-1:0] r_repeat, r_period, r_period_cnt, r_inj_count;
   logic [DLY_WIDTH-1:0] r_inj_width, r_trig_delay, r_trig_width, r_phase_cnt;
   logic                 r_inj_pulse, r_trig, r_busy, r_paused, r_done;
   logic                 w_start_acc, w_phase_last, w_period_done;
   logic [CNT_WIDTH:0]   w_period_inc;

   // ABORT in the same IDLE cycle blocks START
   assign w_start_acc   = (r_state == StIdle) && START && !ABORT;
   // Widened compare so PERIOD=0 and PERIOD=1 both exit WAIT after one cycle
   assign w_period_inc  = {1'b0, r_period_cnt} + CntOneW;
   assign w_period_done = (w_period_inc >= {1'b0, r_period});

   // Last cycle of the current timed phase
   always_comb begin
      w_phase_last = 1'b0;
      case (r_state)
         StInj:   w_phase_last = (r_phase_cnt == r_inj_width - DlyOne);
         StDelay: w_phase_last = (r_phase_cnt == r_trig_delay - DlyOne);
         StTrig:  w_phase_last = (r_phase_cnt == r_trig_width - DlyOne);
         default: w_phase_last = 1'b0;
      endcase
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle: begin
            if (w_start_acc) w_state_d = (REPEAT == '0) ? StDone : StInj;
         end
         StInj: begin
            if (w_phase_last) begin
               if (r_trig_delay != '0)      w_state_d = StDelay;
               else if (r_trig_width != '0) w_state_d = StTrig;
               else                         w_state_d = StWait;
            end
         end
         StDelay: begin
            if (w_phase_last) w_state_d = (r_trig_width != '0) ? StTrig : StWait;
         end
         StTrig: begin
            if (w_phase_last) w_state_d = StWait;
         end
         StWait: begin
            if (w_period_done) begin
               if (r_inj_count == r_repeat) w_state_d = StDone;
               else if (FIFO_NEAR_FULL)     w_state_d = StHold;
               else                         w_state_d = StInj;
            end
         end
         StHold: begin
            if (!FIFO_NEAR_FULL) w_state_d = StInj;
         end
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
      if (ABORT && (r_state != StIdle)) w_state_d = StIdle;
   end

   // State, phase counter and period counter (period restarts on every INJ entry)
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         r_state      <= StIdle;
         r_phase_cnt  <= '0;
         r_period_cnt <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_state_d != r_state)  r_phase_cnt <= '0;
         else if (r_phase_cnt != '1) r_phase_cnt <= r_phase_cnt + DlyOne;
         if ((w_state_d == StInj) && (r_state != StInj)) r_period_cnt <= '0;
         else if (r_period_cnt != '1)                    r_period_cnt <= r_period_cnt + CntOne;
      end
   end

   // Configuration snapshot taken on an accepted START
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         r_repeat     <= '0;
         r_period     <= '0;
         r_inj_width  <= DlyOne;
         r_trig_delay <= '0;
         r_trig_width <= '0;
      end else if (w_start_acc) begin
         r_repeat     <= REPEAT;
         r_period     <= PERIOD;
         r_inj_width  <= (INJ_WIDTH == '0) ? DlyOne : INJ_WIDTH;
         r_trig_delay <= TRIG_DELAY;
         r_trig_width <= TRIG_WIDTH;
      end
   end

   // Injection counter: cleared on START, bumped on the last INJ cycle unless aborted
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         r_inj_count <= '0;
      end else if (w_start_acc) begin
         r_inj_count <= '0;
      end else if ((r_state == StInj) && w_phase_last && !ABORT) begin
         r_inj_count <= r_inj_count + CntOne;
      end
   end

   // Outputs registered from the next state so they align with it and never glitch
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         r_inj_pulse <= 1'b0;
         r_trig      <= 1'b0;
         r_busy      <= 1'b0;
         r_paused    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_inj_pulse <= (w_state_d == StInj);
         r_trig      <= (w_state_d == StTrig);
         r_busy      <= (w_state_d != StIdle) && (w_state_d != StDone);
         r_paused    <= (w_state_d == StHold);
         r_done      <= (w_state_d == StDone);
      end
   end

   assign INJ_PULSE = r_inj_pulse;
   assign TRIG      = r_trig;
   assign BUSY      = r_busy;
   assign PAUSED    = r_paused;
   assign DONE      = r_done;
   assign INJ_COUNT = r_inj_count;

endmodule

// File: tb/tb_inj_trig_sequencer.sv
// Bench for inj_trig_sequencer: a per-scenario schedule model builds the expected
// waveform of every output, then the DUT is run and compared cycle by cycle.
module tb_inj_trig_sequencer;

   localparam int CW   = 16;
   localparam int DW   = 8;
   localparam int MAXC = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0, fnf = 1'b0;
   logic [CW-1:0] repeat_cfg = '0, period = '0;
   logic [DW-1:0] inj_width = '0, trig_delay = '0, trig_width = '0;
   logic          inj_pulse, trig, busy, paused, done;
   logic [CW-1:0] inj_count;

   always #5 clk = ~clk;

   inj_trig_sequencer #(.CNT_WIDTH(CW), .DLY_WIDTH(DW)) dut (
      .BUS_CLK        (clk),
      .BUS_RST_N      (rst_n),
      .START          (start),
      .ABORT          (abort),
      .REPEAT         (repeat_cfg),
      .INJ_WIDTH      (inj_width),
      .TRIG_DELAY     (trig_delay),
      .TRIG_WIDTH     (trig_width),
      .PERIOD         (period),
      .FIFO_NEAR_FULL (fnf),
      .INJ_PULSE      (inj_pulse),
      .TRIG           (trig),
      .BUSY           (busy),
      .PAUSED         (paused),
      .DONE           (done),
      .INJ_COUNT      (inj_count)
   );

   int checks = 0;
   int errors = 0;

   // Expected outputs per cycle; cycle 0 is the cycle START is presented
   int exp_inj[MAXC], exp_trig[MAXC], exp_busy[MAXC];
   int exp_paused[MAXC], exp_done[MAXC], exp_cnt[MAXC];
   bit fnf_tab[MAXC];
   int run_len;
   int last_cnt = 0;
   int s_rep, s_iw, s_td, s_tw, s_per, s_abort;

   task automatic check(input string tag, input int c, input logic [31:0] obs,
                        input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s cycle %0d: got %0d expected %0d", tag, c, obs, exp_v);
      end
   endtask

   task automatic clear_fnf();
      for (int i = 0; i < MAXC; i++) fnf_tab[i] = 1'b0;
   endtask

   task automatic set_fnf(input int from, input int upto);
      for (int i = from; i <= upto && i < MAXC; i++) fnf_tab[i] = 1'b1;
   endtask

   // Schedule model: walk injections by start time using phase lengths and spacing
   task automatic build_model();
      int t, n, iw, act, plen, we, c, endc;
      for (int i = 0; i < MAXC; i++) begin
         exp_inj[i] = 0; exp_trig[i] = 0; exp_busy[i] = 0;
         exp_paused[i] = 0; exp_done[i] = 0; exp_cnt[i] = last_cnt;
      end
      if (s_abort == 0) begin
         run_len = 4;
         return;
      end
      for (int i = 1; i < MAXC; i++) exp_cnt[i] = 0;
      n = 0;
      if (s_rep == 0) begin
         exp_done[1] = 1;
         endc = 1;
      end else begin
         iw   = (s_iw == 0) ? 1 : s_iw;
         act  = iw + s_td + s_tw;
         plen = (s_per > act + 1) ? s_per : act + 1;
         t    = 1;
         forever begin
            we = t + plen - 1;
            for (int k = t; k <= we; k++) begin
               exp_busy[k] = 1;
               exp_cnt[k]  = (k < t + iw) ? n : n + 1;
            end
            for (int k = t; k < t + iw; k++) exp_inj[k] = 1;
            for (int k = t + iw + s_td; k < t + iw + s_td + s_tw; k++) exp_trig[k] = 1;
            n++;
            if (n == s_rep) begin
               exp_done[we + 1] = 1;
               exp_cnt[we + 1]  = n;
               endc = we + 1;
               break;
            end
            if (fnf_tab[we]) begin
               c = we + 1;
               forever begin
                  exp_busy[c] = 1; exp_paused[c] = 1; exp_cnt[c] = n;
                  if (!fnf_tab[c] || c >= MAXC - 100) break;
                  c++;
               end
               t = c + 1;
            end else begin
               t = we + 1;
            end
         end
      end
      for (int i = endc + 1; i < MAXC; i++) exp_cnt[i] = n;
      if (s_abort >= 1 && s_abort <= endc) begin
         for (int i = s_abort + 1; i < MAXC; i++) begin
            exp_inj[i] = 0; exp_trig[i] = 0; exp_busy[i] = 0;
            exp_paused[i] = 0; exp_done[i] = 0; exp_cnt[i] = exp_cnt[s_abort];
         end
         endc = s_abort;
      end
      run_len = endc + 4;
   endtask

   task automatic run_scenario(input string tag);
      build_model();
      for (int c = 0; c < run_len; c++) begin
         @(negedge clk);
         check({tag, ".inj"},    c, 32'(inj_pulse), exp_inj[c]);
         check({tag, ".trig"},   c, 32'(trig),      exp_trig[c]);
         check({tag, ".busy"},   c, 32'(busy),      exp_busy[c]);
         check({tag, ".paused"}, c, 32'(paused),    exp_paused[c]);
         check({tag, ".done"},   c, 32'(done),      exp_done[c]);
         check({tag, ".count"},  c, 32'(inj_count), exp_cnt[c]);
         start = (c == 0);
         abort = (c == s_abort);
         fnf   = fnf_tab[c];
         if (c == 0) begin
            repeat_cfg = CW'(s_rep);   period     = CW'(s_per);
            inj_width  = DW'(s_iw);    trig_delay = DW'(s_td);
            trig_width = DW'(s_tw);
         end else begin
            // Config churn while running must be ignored
            repeat_cfg = CW'($urandom_range(0, 9));  period     = CW'($urandom_range(0, 60));
            inj_width  = DW'($urandom_range(0, 9));  trig_delay = DW'($urandom_range(0, 9));
            trig_width = DW'($urandom_range(0, 9));
         end
      end
      last_cnt = exp_cnt[run_len - 1];
      @(negedge clk);
      start = 1'b0; abort = 1'b0; fnf = 1'b0;
   endtask

   task automatic set_cfg(input int rep, input int iw, input int td, input int tw,
                          input int per, input int ab);
      s_rep = rep; s_iw = iw; s_td = td; s_tw = tw; s_per = per; s_abort = ab;
      clear_fnf();
   endtask

   initial begin
      // Reset values
      #2;
      check("rst.inj",   0, 32'(inj_pulse), 0);
      check("rst.trig",  0, 32'(trig),      0);
      check("rst.busy",  0, 32'(busy),      0);
      check("rst.paused",0, 32'(paused),    0);
      check("rst.done",  0, 32'(done),      0);
      check("rst.count", 0, 32'(inj_count), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Basic scan: INJ 1-4/41-44/81-84, TRIG 15-16/55-56/95-96, DONE 121
      set_cfg(3, 4, 10, 2, 40, -1);
      run_scenario("basic");
      // Short period: WAIT minimum one cycle, spacing 4
      set_cfg(2, 2, 0, 1, 1, -1);
      run_scenario("minwait");
      // REPEAT=0: DONE at cycle 1 only
      set_cfg(0, 4, 10, 2, 40, -1);
      run_scenario("rep0");
      // Back-pressure: PAUSED 41-61, second INJ at 62, TRIG 76-77
      set_cfg(3, 4, 10, 2, 40, -1);
      set_fnf(30, 60);
      run_scenario("hold");
      // Abort during TRIG at cycle 16, then immediate restart
      set_cfg(3, 4, 10, 2, 40, 16);
      run_scenario("abort");
      set_cfg(2, 3, 1, 1, 12, -1);
      run_scenario("restart");
      // START with ABORT in IDLE: ignored
      set_cfg(3, 4, 10, 2, 40, 0);
      run_scenario("startabort");
      // No trigger, period still honoured
      set_cfg(3, 3, 2, 0, 20, -1);
      run_scenario("notrig");
      // INJ_WIDTH=0 behaves as 1, PERIOD=0
      set_cfg(3, 0, 0, 0, 0, -1);
      run_scenario("zeros");

      // Randomized scans
      for (int r = 0; r < 30; r++) begin
         set_cfg($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 6),
                 $urandom_range(0, 4), $urandom_range(0, 40), -1);
         if ($urandom_range(0, 1) == 1) begin
            int f0;
            f0 = $urandom_range(1, 200);
            set_fnf(f0, f0 + $urandom_range(0, 50));
         end
         if ($urandom_range(0, 3) == 0) s_abort = $urandom_range(1, 250);
         run_scenario($sformatf("rnd%0d", r));
      end

      // Reset asserted mid-sequence: outputs drop at once and the scan does not resume
      @(negedge clk);
      repeat_cfg = 16'd3; inj_width = 8'd4; trig_delay = 8'd10; trig_width = 8'd2;
      period = 16'd40; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      check("midrst.busy_before", 11, 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.inj",   0, 32'(inj_pulse), 0);
      check("midrst.busy",  0, 32'(busy),      0);
      check("midrst.count", 0, 32'(inj_count), 0);
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         check("postrst.inj",  c, 32'(inj_pulse), 0);
         check("postrst.trig", c, 32'(trig),      0);
         check("postrst.busy", c, 32'(busy),      0);
         check("postrst.done", c, 32'(done),      0);
      end
      last_cnt = 0;
      set_cfg(1, 2, 1, 1, 6, -1);
      run_scenario("afterrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
